// File: rtl/alu_mdu_pkg.sv
// Shared ALUOp encoding and MDU FSM state constants for the execute-stage ALU/MDU.
package alu_mdu_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_ADDU  = 5'd1,
      OP_ADDI  = 5'd2,
      OP_SUB   = 5'd3,
      OP_SUBU  = 5'd4,
      OP_SLT   = 5'd5,
      OP_SLTU  = 5'd6,
      OP_AND   = 5'd7,
      OP_OR    = 5'd8,
      OP_ORI   = 5'd9,
      OP_XOR   = 5'd10,
      OP_NOR   = 5'd11,
      OP_SLL   = 5'd12,
      OP_SRL   = 5'd13,
      OP_SRA   = 5'd14,
      OP_LUI   = 5'd15,
      OP_J     = 5'd16,
      OP_JR    = 5'd17,
      OP_JAL   = 5'd18,
      OP_MFHI  = 5'd19,
      OP_MFLO  = 5'd20,
      OP_MTHI  = 5'd21,
      OP_MTLO  = 5'd22,
      OP_MULT  = 5'd23,
      OP_MULTU = 5'd24,
      OP_DIV   = 5'd25,
      OP_DIVU  = 5'd26
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles plus a sign-fix cycle. Divider present only with ALU_MDU_DIV_EN.
module mdu_iter
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic [SHW:0]       cnt_q, cnt_d;
   logic               md_done_q, md_done_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
   logic               neg_res_q, neg_res_d;
   logic               is_mul_op, is_div_op, launch, signed_op;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign launch    = start && (state_q == MD_IDLE) && (is_mul_op || is_div_op);

   // Multiplier: {acc_hi, acc_lo} shifts right, adding the multiplicand when the LSB is set
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_res = neg_2w({acc_hi_q, acc_lo_q}, neg_res_q);

`ifdef ALU_MDU_DIV_EN
   logic           is_div_q, is_div_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
   logic [WIDTH:0] rem_sh, rem_sub;

   assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);

   always_comb begin
      is_div_d  = launch ? is_div_op : is_div_q;
      neg_rem_d = launch ? (signed_op & a[WIDTH-1]) : neg_rem_q;
      dz_d      = launch ? (b == '0) : dz_q;
      rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
      rem_sub   = rem_sh - {1'b0, opnd_q};
      if (is_div_q) begin
         // Restoring step: keep the shifted remainder when the trial subtract goes negative
         step_hi = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], ~rem_sub[WIDTH]};
         fix_hi  = neg_w(acc_hi_q, neg_rem_q);
         fix_lo  = dz_q ? '1 : neg_w(acc_lo_q, neg_res_q);
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
         fix_hi  = mul_res[2*WIDTH-1:WIDTH];
         fix_lo  = mul_res[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
   end
`else
   assign is_div_op = 1'b0;

   always_comb begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      fix_hi  = mul_res[2*WIDTH-1:WIDTH];
      fix_lo  = mul_res[WIDTH-1:0];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= MD_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (launch) state_d = MD_RUN;
         MD_RUN:  if (cnt_q == CNT_LAST) state_d = MD_FIX;
         MD_FIX:  state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != MD_IDLE);
   end

   always_comb begin
      cnt_d     = cnt_q;
      md_done_d = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
      case (state_q)
         MD_IDLE: begin
            if (launch) begin
               // Iterate on magnitudes; the sign is restored in the fix cycle
               cnt_d     = '0;
               acc_hi_d  = '0;
               acc_lo_d  = neg_w(a, signed_op & a[WIDTH-1]);
               opnd_d    = neg_w(b, signed_op & b[WIDTH-1]);
               neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (start && (op == OP_MTHI)) begin
               hi_d = a;
            end else if (start && (op == OP_MTLO)) begin
               lo_d = a;
            end
         end
         MD_RUN: begin
            cnt_d    = cnt_q + 1'b1;
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
         end
         MD_FIX: begin
            hi_d      = fix_hi;
            lo_d      = fix_lo;
            md_done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         md_done_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         md_done_q <= md_done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
   end

   assign md_done = md_done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: zero-latency combinational ops plus the iterative MDU (mdu_iter).
// Build with ALU_MDU_DIV_EN defined to include DIV/DIVU support.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       ALUOp,
   input  logic             start,
   output logic [WIDTH-1:0] C,
   output logic             Zero,
   output logic             Overflow,
   output logic             busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   alu_op_e                 op;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH-1:0]        sum, diff, alu_c;
   logic [SHW-1:0]          sh;
   logic                    ovf;

   assign op   = alu_op_e'(ALUOp);
   assign a_s  = A;
   assign b_s  = B;
   assign sum  = A + B;
   assign diff = A - B;
   assign sh   = A[SHW-1:0];

   mdu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mdu (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (A),
      .b       (B),
      .busy    (busy),
      .md_done (md_done),
      .hi      (hi),
      .lo      (lo)
   );

   always_comb begin
      alu_c = A;
      ovf   = 1'b0;
      case (op)
         OP_ADDU, OP_ADDI: alu_c = sum;
         OP_ADD: begin
            alu_c = sum;
            ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUBU: alu_c = diff;
         OP_SUB: begin
            alu_c = diff;
            ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT:        alu_c = {{(WIDTH-1){1'b0}}, a_s < b_s};
         OP_SLTU:       alu_c = {{(WIDTH-1){1'b0}}, A < B};
         OP_AND:        alu_c = A & B;
         OP_OR, OP_ORI: alu_c = A | B;
         OP_XOR:        alu_c = A ^ B;
         OP_NOR:        alu_c = ~(A | B);
         OP_SLL:        alu_c = B << sh;
         OP_SRL:        alu_c = B >> sh;
         OP_SRA:        alu_c = b_s >>> sh;
         OP_LUI:        alu_c = B;
         OP_MFHI:       alu_c = hi;
         OP_MFLO:       alu_c = lo;
         default:       alu_c = A;
      endcase
   end

   assign C        = alu_c;
   assign Zero     = (A == B);
   assign Overflow = ovf;

endmodule
